// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the RV32I memory stage: funct3 access codes,
// result-source selects and the bus-transaction state machine states.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for loads and stores, plus detection of accesses that
// must never reach the bus (misaligned or unsupported funct3).
import riscv_mem_pkg::*;

module load_store_align (
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        illegal
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        bad_funct3;
    logic        misaligned;

    always_comb begin
        lane_byte = rdata[{addr_lo, 3'b000} +: 8];
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_LBU:  load_data = {24'd0, lane_byte};
            F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            F3_LHU:  load_data = {16'd0, lane_half};
            F3_LW:   load_data = rdata;
            default: load_data = 32'd0;
        endcase

        // Sub-word stores replicate data across the word so the strobe alone selects the lane
        case (funct3)
            F3_SB: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            F3_SH: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << addr_lo;
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
        endcase

        bad_funct3 = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (is_store & funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0])
                   | ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
        illegal    = bad_funct3 | misaligned;
    end

endmodule

// File: rtl/memory_access_cycle.sv
// M stage of the RV32I pipeline: issues one valid/ready data-memory transaction
// per load/store, stalls upstream until the response, and registers the W bundle.
import riscv_mem_pkg::*;

module memory_access_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic        ErrW
);

    mem_state_t  state;
    logic        access;
    logic        illegal;
    logic        go;
    logic        rsp_done;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] load_data;

    load_store_align u_align (
        .funct3     (Funct3M),
        .is_store   (MemWriteM),
        .addr_lo    (ALU_ResultM[1:0]),
        .store_data (WriteDataM),
        .rdata      (dmem_rdata),
        .wdata      (lane_wdata),
        .wstrb      (lane_wstrb),
        .load_data  (load_data),
        .illegal    (illegal)
    );

    assign access   = MemWriteM | (ResultSrcM == RES_MEM);
    assign go       = access & ~illegal;
    assign rsp_done = (state == WAIT_RSP) & dmem_rsp_valid;

    // Bus fields are forced to zero whenever no request is being presented
    assign dmem_req_valid = ~rst & (((state == IDLE) & go) | (state == WAIT_REQ));
    assign dmem_we        = dmem_req_valid & MemWriteM;
    assign dmem_addr      = dmem_req_valid ? {ALU_ResultM[31:2], 2'b00} : 32'd0;
    assign dmem_wdata     = dmem_we ? lane_wdata : 32'd0;
    assign dmem_wstrb     = dmem_we ? lane_wstrb : 4'd0;
    assign StallM         = ~rst & go & ~rsp_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'd0;
            RD_W        <= 5'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            PCPlus4W    <= 32'd0;
            ErrW        <= 1'b0;
        end else begin
            case (state)
                IDLE:     if (go) state <= dmem_req_ready ? WAIT_RSP : WAIT_REQ;
                WAIT_REQ: if (dmem_req_ready) state <= WAIT_RSP;
                WAIT_RSP: if (dmem_rsp_valid) state <= IDLE;
                default:  state <= IDLE;
            endcase

            if (StallM) begin
                RegWriteW   <= 1'b0;
                ResultSrcW  <= 2'd0;
                RD_W        <= 5'd0;
                ALU_ResultW <= 32'd0;
                ReadDataW   <= 32'd0;
                PCPlus4W    <= 32'd0;
                ErrW        <= 1'b0;
            end else begin
                RegWriteW   <= RegWriteM & ~(access & illegal);
                ResultSrcW  <= ResultSrcM;
                RD_W        <= RD_M;
                ALU_ResultW <= ALU_ResultM;
                ReadDataW   <= (go & ~MemWriteM) ? load_data : 32'd0;
                PCPlus4W    <= PCPlus4M;
                ErrW        <= access & illegal;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Directed bench for memory_access_cycle: a transaction-level model predicts
// bus, stall and W-stage values; one process compares them every cycle.
module tb_memory_access_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        StallM, RegWriteW, ErrW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

    memory_access_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .ErrW(ErrW)
    );

    always #5 clk = ~clk;

    // kind: 0 nothing to check, 1 bubble, 2 bundle, 3 bundle + read data
    typedef struct packed {
        logic [1:0]  kind;
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] pc4;
        logic        err;
    } wexp_t;

    int total = 0;
    int bad   = 0;

    logic        chk_bus = 1'b0;
    logic        exp_req, exp_stall, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    wexp_t       w_next = '0;
    wexp_t       w_cur  = '0;
    wexp_t       bubble;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 0;
        if (st && (f3 == 3'b100 || f3 == 3'b101)) return 0;
        return (int'(a) % acc_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = '0;
        for (int lane = 0; lane < 4; lane++)
            r[8*lane +: 8] = wd[8*(lane % acc_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] r = '0;
        for (int lane = 0; lane < 4; lane++)
            r[lane] = (lane >= int'(a)) && (lane < int'(a) + acc_size(f3));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
        logic [31:0] v, mask;
        int bits;
        bits = 8 * acc_size(f3);
        v    = word >> (8 * int'(a));
        if (bits < 32) begin
            mask = (32'd1 << bits) - 32'd1;
            v    = v & mask;
            if (!f3[2] && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    always @(posedge clk) w_cur <= w_next;

    always @(negedge clk) begin
        if (chk_bus) begin
            check("req_valid", dmem_req_valid, exp_req);
            check("stall", StallM, exp_stall);
            if (exp_req) begin
                check("addr", dmem_addr, exp_addr);
                check("we", dmem_we, exp_we);
                check("wstrb", dmem_wstrb, exp_wstrb);
                if (exp_we) check("wdata", dmem_wdata, exp_wdata);
            end
        end
        if (w_cur.kind != 2'd0) begin
            check("RegWriteW", RegWriteW, w_cur.rw);
            check("ErrW", ErrW, w_cur.err);
        end
        if (w_cur.kind >= 2'd2) begin
            check("ResultSrcW", ResultSrcW, w_cur.rs);
            check("RD_W", RD_W, w_cur.rd);
            check("ALU_ResultW", ALU_ResultW, w_cur.alu);
            check("PCPlus4W", PCPlus4W, w_cur.pc4);
        end
        if (w_cur.kind == 2'd3) check("ReadDataW", ReadDataW, w_cur.rdat);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic rw, input logic ms, input logic [1:0] rs,
                            input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [31:0] pc4, input logic [31:0] rdat,
                            input int rdy_dly, input int rsp_dly, input bit stray);
        bit    acc, lg;
        wexp_t w;
        RegWriteM = rw; MemWriteM = ms; ResultSrcM = rs; Funct3M = f3;
        RD_M = rd; ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
        acc = ms || (rs == 2'b01);
        lg  = m_legal(ms, f3, alu[1:0]);
        w = '{kind: 2'd2, rw: rw, rs: rs, rd: rd, alu: alu, rdat: 32'd0, pc4: pc4, err: 1'b0};
        exp_addr  = {alu[31:2], 2'b00};
        exp_we    = ms;
        exp_wdata = m_wdata(f3, wd);
        exp_wstrb = ms ? m_wstrb(f3, alu[1:0]) : 4'd0;
        if (!acc || !lg) begin
            if (acc) begin w.rw = 1'b0; w.err = 1'b1; end
            exp_req = 1'b0; exp_stall = 1'b0;
            dmem_req_ready = 1'b0; dmem_rsp_valid = stray; dmem_rdata = 32'hDEAD_BEEF;
            w_next = w;
            tick();
        end else begin
            for (int c = 0; c <= rdy_dly; c++) begin
                exp_req = 1'b1; exp_stall = 1'b1;
                dmem_req_ready = (c == rdy_dly);
                dmem_rsp_valid = stray && (c == 0);
                dmem_rdata = 32'hDEAD_BEEF;
                w_next = bubble;
                tick();
            end
            for (int c = 0; c <= rsp_dly; c++) begin
                exp_req = 1'b0;
                dmem_req_ready = 1'b0;
                dmem_rsp_valid = (c == rsp_dly);
                dmem_rdata = (c == rsp_dly) ? rdat : 32'h5A5A_5A5A;
                exp_stall = (c != rsp_dly);
                if (c == rsp_dly) begin
                    w.kind = 2'd3;
                    w.rdat = ms ? 32'd0 : m_load(f3, alu[1:0], rdat);
                    w_next = w;
                end else begin
                    w_next = bubble;
                end
                tick();
            end
        end
    endtask

    task automatic nop();
        do_instr(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 1'b0);
    endtask

    initial begin
        bubble = '0;
        bubble.kind = 2'd1;
        rst = 1'b1;
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; Funct3M = 0; RD_M = 0;
        ALU_ResultM = 0; WriteDataM = 0; PCPlus4M = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
        exp_req = 0; exp_stall = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
        w_next = '0; w_next.kind = 2'd3;
        tick();
        tick();
        rst = 1'b0;
        chk_bus = 1'b1;

        // ADD passthrough
        do_instr(1'b1, 1'b0, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h8, 32'h0, 0, 0, 1'b0);
        check("pin_add_alu", ALU_ResultW, 32'h0000_1234);
        check("pin_add_rw", RegWriteW, 1'b1);
        // LB / LBU at byte 3
        do_instr(1'b1, 1'b0, 2'b01, 3'b000, 5'd6, 32'h103, 32'h0, 32'h10, 32'h80FF_0000, 0, 0, 1'b0);
        check("pin_lb", ReadDataW, 32'hFFFF_FF80);
        do_instr(1'b1, 1'b0, 2'b01, 3'b100, 5'd6, 32'h103, 32'h0, 32'h14, 32'h80FF_0000, 0, 0, 1'b0);
        check("pin_lbu", ReadDataW, 32'h0000_0080);
        // SH with slow ready
        do_instr(1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h202, 32'hAAAA_BEEF, 32'h18, 32'h0, 3, 0, 1'b0);
        check("pin_sh_rw", RegWriteW, 1'b0);
        // misaligned LW
        do_instr(1'b1, 1'b0, 2'b01, 3'b010, 5'd3, 32'h101, 32'h0, 32'h1C, 32'h0, 0, 0, 1'b0);
        check("pin_lw_err", ErrW, 1'b1);
        check("pin_lw_rw", RegWriteW, 1'b0);
        nop();
        // more lanes, sizes and illegal forms
        do_instr(1'b1, 1'b0, 2'b01, 3'b001, 5'd11, 32'h104, 32'h0, 32'h20, 32'h1234_8765, 1, 2, 1'b0);
        check("pin_lh", ReadDataW, 32'hFFFF_8765);
        do_instr(1'b1, 1'b0, 2'b01, 3'b101, 5'd12, 32'h106, 32'h0, 32'h24, 32'h8001_2345, 0, 1, 1'b0);
        check("pin_lhu", ReadDataW, 32'h0000_8001);
        do_instr(1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h301, 32'h0000_0055, 32'h28, 32'h0, 1, 0, 1'b0);
        do_instr(1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h400, 32'hCAFE_F00D, 32'h2C, 32'h0, 0, 0, 1'b0);
        do_instr(1'b0, 1'b1, 2'b00, 3'b100, 5'd0, 32'h404, 32'h1, 32'h30, 32'h0, 0, 0, 1'b0);
        do_instr(1'b1, 1'b0, 2'b01, 3'b011, 5'd13, 32'h408, 32'h0, 32'h34, 32'h0, 0, 0, 1'b0);
        do_instr(1'b1, 1'b0, 2'b01, 3'b001, 5'd14, 32'h105, 32'h0, 32'h38, 32'h0, 0, 0, 1'b0);
        do_instr(1'b1, 1'b0, 2'b10, 3'b111, 5'd15, 32'h999, 32'h0, 32'h3C, 32'h0, 0, 0, 1'b0);

        // reset while waiting for a response
        RegWriteM = 1; MemWriteM = 0; ResultSrcM = 2'b01; Funct3M = 3'b010; RD_M = 5'd7;
        ALU_ResultM = 32'h40; WriteDataM = 0; PCPlus4M = 32'h40;
        exp_req = 1; exp_stall = 1; exp_addr = 32'h40; exp_we = 0; exp_wstrb = 0;
        dmem_req_ready = 1; dmem_rsp_valid = 0;
        w_next = bubble;
        tick();
        rst = 1'b1; chk_bus = 1'b0; dmem_req_ready = 0;
        w_next = '0; w_next.kind = 2'd3;
        tick();
        rst = 1'b0; chk_bus = 1'b1;
        check("pin_rst_rd", RD_W, 5'd0);
        check("pin_rst_rdata", ReadDataW, 32'd0);
        do_instr(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 1'b1);
        do_instr(1'b1, 1'b0, 2'b01, 3'b010, 5'd8, 32'h80, 32'h0, 32'h44, 32'h1122_3344, 1, 0, 1'b1);
        check("pin_lw_after_rst", ReadDataW, 32'h1122_3344);

        // back-to-back loads with two-cycle response latency
        do_instr(1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h84, 32'h0, 32'h48, 32'hA5A5_0001, 0, 1, 1'b0);
        check("pin_b2b_first", ReadDataW, 32'hA5A5_0001);
        do_instr(1'b1, 1'b0, 2'b01, 3'b010, 5'd10, 32'h88, 32'h0, 32'h4C, 32'h0BAD_F00D, 0, 1, 1'b0);
        check("pin_b2b_second", ReadDataW, 32'h0BAD_F00D);
        check("pin_b2b_rd", RD_W, 5'd10);
        nop();
        nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
